// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_src_e;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_LIM = 2;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Latency counter: loads MEM_LAT-1 on a grant, then counts down to a zero flag.
module lat_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= LOAD_VAL;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between the IF and MEM ports,
// with data priority bounded by a starvation limit and fetch kill on flush.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIM);

  arb_state_e        state;
  logic [SW-1:0]     streak;
  logic              drop;
  logic              cnt_zero;
  logic              contested;
  logic              gnt_any;
  gnt_src_e          gnt_src;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk   (clk),
    .reset (reset),
    .load  (gnt_any),
    .dec   (state != IDLE),
    .zero  (cnt_zero)
  );

  // Grant decision: only in IDLE; a killed fetch never competes.
  always_comb begin
    contested = if_req && d_req && !if_kill;
    gnt_any   = 1'b0;
    gnt_src   = GNT_D;
    if (state == IDLE && !reset) begin
      if (d_req && !(contested && streak == STREAK_MAX)) begin
        gnt_any = 1'b1;
        gnt_src = GNT_D;
      end else if (if_req && !if_kill) begin
        gnt_any = 1'b1;
        gnt_src = GNT_I;
      end
    end
  end

  always_comb begin
    mem_en    = gnt_any;
    mem_we    = gnt_any && gnt_src == GNT_D && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_any)
      mem_addr = (gnt_src == GNT_D) ? d_addr : if_addr;
    if (mem_we)
      mem_wdata = d_wdata;
  end

  // Response cycle: ready is combinational so a same-cycle kill can still suppress it.
  always_comb begin
    if_ready = !reset && state == BUSY_I && cnt_zero && !drop && !if_kill;
    d_ready  = !reset && state == BUSY_D && cnt_zero;
    if_rdata = if_ready ? mem_rdata : if_rdata_q;
    d_rdata  = d_ready  ? mem_rdata : d_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      streak     <= '0;
      drop       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_ready) if_rdata_q <= mem_rdata;
      if (d_ready)  d_rdata_q  <= mem_rdata;
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (gnt_any) begin
            state  <= (gnt_src == GNT_D) ? BUSY_D : BUSY_I;
            streak <= (gnt_src == GNT_D && contested) ? streak + 1'b1 : '0;
          end
        end
        BUSY_I: begin
          if (cnt_zero) begin
            state <= IDLE;
            drop  <= 1'b0;
          end else if (if_kill) begin
            drop <= 1'b1;
          end
        end
        BUSY_D: begin
          if (cnt_zero)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a transaction-timeline reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SLIM = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_kill, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          if_ready, d_ready, mem_en, mem_we;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_LIM(SLIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3} ^ 32'h1234_0000;
  endfunction

  // Memory environment: fixed latency LAT, junk on the bus when no read is due.
  logic [DW-1:0] env_mem [256];
  bit            env_wr  [256];
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    if (mem_en)
      rd_pipe[0] <= env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_word(mem_addr[7:0]);
    else
      rd_pipe[0] <= $urandom;
    if (mem_en && mem_we) begin
      env_mem[mem_addr[7:0]] <= mem_wdata;
      env_wr[mem_addr[7:0]]  <= 1'b1;
    end
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: transaction timeline (grant cycle, response cycle) and a word array.
  logic [31:0] ref_mem [256];
  bit          busy = 0, busy_d = 0, drop_m = 0;
  int          resp_at = 0, streak_m = 0;
  logic [31:0] exp_data = '0, held_i = '0, held_d = '0;

  logic        e_en, e_we, e_ir, e_dr;
  logic [31:0] e_addr, e_wd;
  logic        o_en, o_we, o_ir, o_dr;
  logic [31:0] o_addr, o_wd, o_ird, o_drd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    bit contested;
    logic [7:0] a;
    e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_ir = 0; e_dr = 0;
    contested = if_req && d_req && !if_kill;
    if (!reset) begin
      if (busy && cyc == resp_at) begin
        if (busy_d) begin
          e_dr = 1; held_d = exp_data;
        end else if (!drop_m && !if_kill) begin
          e_ir = 1; held_i = exp_data;
        end
      end else if (busy) begin
        if (!busy_d && if_kill) drop_m = 1;
      end else if (d_req && !(contested && streak_m == SLIM)) begin
        a = d_addr[7:0];
        e_en = 1; e_we = d_we; e_addr = d_addr; e_wd = d_we ? d_wdata : '0;
        exp_data = ref_mem[a];
        if (d_we) ref_mem[a] = d_wdata;
        streak_m = contested ? streak_m + 1 : 0;
        busy = 1; busy_d = 1; resp_at = cyc + LAT; drop_m = 0;
      end else if (if_req && !if_kill) begin
        e_en = 1; e_addr = if_addr;
        exp_data = ref_mem[if_addr[7:0]];
        streak_m = 0;
        busy = 1; busy_d = 0; resp_at = cyc + LAT; drop_m = 0;
      end
    end
    @(negedge clk);
    o_en = mem_en; o_we = mem_we; o_addr = mem_addr; o_wd = mem_wdata;
    o_ir = if_ready; o_dr = d_ready; o_ird = if_rdata; o_drd = d_rdata;
    chk("mem_en", o_en, e_en);
    chk("mem_we", o_we, e_we);
    chk("mem_addr", o_addr, e_addr);
    chk("mem_wdata", o_wd, e_wd);
    chk("if_ready", o_ir, e_ir);
    chk("d_ready", o_dr, e_dr);
    chk("if_rdata", o_ird, held_i);
    chk("d_rdata", o_drd, held_d);
    if (reset) begin
      busy = 0; streak_m = 0; drop_m = 0; held_i = '0; held_d = '0;
    end else if (busy && cyc == resp_at) begin
      busy = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_kill = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  int  gcyc [8];
  bit  gsrc [8];
  int  ng;
  bit  exp_src [6] = '{1, 1, 0, 1, 1, 0};
  bit  any_ir;
  bit  i_pend, d_pend;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    reset = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    tick();
    chk("rst_if_rdata", o_ird, 32'h0);
    chk("rst_d_rdata", o_drd, 32'h0);
    chk("rst_mem_en", o_en, 1'b0);
    reset = 0;
    tick();

    // Single load
    d_req = 1; d_addr = 32'h10;
    tick();
    chk("load_en_t", o_en, 1'b1);
    chk("load_addr_t", o_addr, 32'h10);
    tick();
    chk("load_en_t1", o_en, 1'b0);
    tick();
    chk("load_ready_t2", o_dr, 1'b1);
    chk("load_en_t2", o_en, 1'b0);
    chk("load_data_t2", o_drd, init_word(8'h10));
    idle_inputs();
    tick();

    // Contention with both requests held high
    if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h44;
    ng = 0;
    for (int c = 0; c < 18; c++) begin
      tick();
      if (o_en && ng < 8) begin
        gcyc[ng] = c; gsrc[ng] = (o_addr == 32'h44); ng++;
      end
    end
    idle_inputs();
    chk("contend_grants", ng, 6);
    for (int k = 0; k < 6; k++) begin
      chk("contend_src", gsrc[k], exp_src[k]);
      if (k > 0) chk("contend_gap", gcyc[k] - gcyc[k-1], LAT + 1);
    end
    tick();

    // Store then load the same address
    any_ir = 0;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin tick(); any_ir |= o_ir; end
    d_we = 0; d_wdata = '0;
    for (int c = 0; c < 3; c++) begin tick(); any_ir |= o_ir; end
    chk("st_ld_ready", o_dr, 1'b1);
    chk("st_ld_data", o_drd, 32'hDEADBEEF);
    chk("st_ld_no_if", any_ir, 1'b0);
    idle_inputs();
    tick();

    // Kill an in-flight fetch while a data request waits
    if_req = 1; if_addr = 32'h80;
    tick();
    chk("kill_grant_t", o_en, 1'b1);
    if_kill = 1; d_req = 1; d_addr = 32'h84;
    tick();
    if_kill = 0; if_req = 0;
    tick();
    chk("kill_no_ready", o_ir, 1'b0);
    tick();
    chk("kill_d_grant", o_en, 1'b1);
    chk("kill_d_addr", o_addr, 32'h84);
    tick();
    tick();
    chk("kill_d_ready", o_dr, 1'b1);
    idle_inputs();
    tick();

    // Reset in the middle of a data transaction
    d_req = 1; d_addr = 32'h30;
    tick();
    reset = 1; d_req = 0;
    tick();
    reset = 0;
    tick();
    chk("mrst_d_ready", o_dr, 1'b0);
    chk("mrst_if_ready", o_ir, 1'b0);
    chk("mrst_mem_en", o_en, 1'b0);
    chk("mrst_mem_addr", o_addr, 32'h0);
    chk("mrst_d_rdata", o_drd, 32'h0);
    chk("mrst_if_rdata", o_ird, 32'h0);
    d_req = 1; d_addr = 32'h34;
    tick(); tick(); tick();
    chk("mrst_new_ready", o_dr, 1'b1);
    chk("mrst_new_data", o_drd, init_word(8'h34));
    idle_inputs();
    tick();

    // Randomized traffic
    i_pend = 0; d_pend = 0;
    for (int c = 0; c < 800; c++) begin
      if (!d_pend && $urandom_range(2) == 0) begin
        d_pend = 1; d_we = $urandom_range(1); d_addr = $urandom; d_wdata = $urandom;
      end
      if (!i_pend && $urandom_range(1) == 0) begin
        i_pend = 1; if_addr = $urandom;
      end
      d_req   = d_pend;
      if_req  = i_pend;
      if_kill = ($urandom_range(9) == 0);
      reset   = ($urandom_range(99) == 0);
      tick();
      if (e_dr) d_pend = 0;
      if (e_ir || if_kill) i_pend = 0;
    end
    reset = 0;
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
